// File: rtl/cu_multicycle_if.sv
// Bus between the multi-cycle control unit and the memory / datapath side.
// master = control unit, slave = memory port plus register file, ALU and PC.
interface cu_multicycle_if #(
   parameter int INSTR_W = 9
);
   logic [INSTR_W-1:0] instr;
   logic               mem_ack;
   logic               zf;
   logic               sf;
   logic               cf;
   logic [1:0]         op;
   logic               imm_sel;
   logic               reg_en;
   logic               ld_sel;
   logic               flag_we;
   logic               ir_load;
   logic               pc_inc;
   logic               pc_load;
   logic               mem_req;
   logic               mem_we;
   logic               mem_addr_sel;
   logic               halted;
   logic               bus_err;
   logic [2:0]         state;

   modport master (
      input  instr, mem_ack, zf, sf, cf,
      output op, imm_sel, reg_en, ld_sel, flag_we, ir_load, pc_inc, pc_load,
             mem_req, mem_we, mem_addr_sel, halted, bus_err, state
   );

   modport slave (
      output instr, mem_ack, zf, sf, cf,
      input  op, imm_sel, reg_en, ld_sel, flag_we, ir_load, pc_inc, pc_load,
             mem_req, mem_we, mem_addr_sel, halted, bus_err, state
   );
endinterface

// File: rtl/cu_multicycle.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM sequencing over a req/ack
// memory handshake, with internal IR, flag register and bus-timeout halt.
module cu_multicycle #(
   parameter int INSTR_W     = 9,
   parameter int MEM_TIMEOUT = 15
) (
   input logic           clk,
   input logic           rst,
   cu_multicycle_if.master bus
);
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_HALT   = 3'd4;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_JZ   = 4'h1;
   localparam logic [3:0] OP_JC   = 4'h2;
   localparam logic [3:0] OP_JGT  = 4'h3;
   localparam logic [3:0] OP_CMPI = 4'h4;
   localparam logic [3:0] OP_CMP  = 4'h8;
   localparam logic [3:0] OP_ST   = 4'hC;
   localparam logic [3:0] OP_LD   = 4'hD;
   localparam logic [3:0] OP_JMP  = 4'hE;
   localparam logic [3:0] OP_HLT  = 4'hF;

   // Counter value during the last request cycle that may still be acked.
   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   logic [2:0]         state_q, state_n;
   logic [INSTR_W-1:0] ir_q;
   logic               zf_q, sf_q, cf_q;
   logic [7:0]         wait_q;
   logic               bus_err_q, bus_err_n;
   logic [3:0]         opc;
   logic               operand_unused;

   logic [1:0] op_c;
   logic       imm_sel_c, reg_en_c, ld_sel_c, flag_we_c, ir_load_c;
   logic       pc_inc_c, pc_load_c, mem_req_c, mem_we_c, mem_addr_sel_c;

   assign opc            = ir_q[INSTR_W-1 -: 4];
   assign operand_unused = ^ir_q[INSTR_W-5:0];

   always_comb begin
      state_n        = state_q;
      bus_err_n      = bus_err_q;
      op_c           = 2'b00;
      imm_sel_c      = 1'b0;
      reg_en_c       = 1'b0;
      ld_sel_c       = 1'b0;
      flag_we_c      = 1'b0;
      ir_load_c      = 1'b0;
      pc_inc_c       = 1'b0;
      pc_load_c      = 1'b0;
      mem_req_c      = 1'b0;
      mem_we_c       = 1'b0;
      mem_addr_sel_c = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req_c = 1'b1;
            if (bus.mem_ack) begin
               ir_load_c = 1'b1;
               pc_inc_c  = 1'b1;
               state_n   = S_DECODE;
            end else if (wait_q == WAIT_LAST) begin
               state_n   = S_HALT;
               bus_err_n = 1'b1;
            end
         end
         S_DECODE: begin
            case (opc)
               OP_NOP: state_n = S_FETCH;
               OP_JZ: begin
                  pc_load_c = zf_q;
                  state_n   = S_FETCH;
               end
               OP_JC: begin
                  pc_load_c = cf_q;
                  state_n   = S_FETCH;
               end
               OP_JGT: begin
                  pc_load_c = !zf_q && !sf_q;
                  state_n   = S_FETCH;
               end
               OP_JMP: begin
                  pc_load_c = 1'b1;
                  state_n   = S_FETCH;
               end
               OP_HLT:       state_n = S_HALT;
               OP_ST, OP_LD: state_n = S_MEM;
               default:      state_n = S_EXEC;
            endcase
         end
         S_EXEC: begin
            op_c      = opc[1:0];
            imm_sel_c = (opc[3:2] == 2'b01);
            flag_we_c = 1'b1;
            reg_en_c  = (opc != OP_CMPI) && (opc != OP_CMP);
            state_n   = S_FETCH;
         end
         S_MEM: begin
            mem_req_c      = 1'b1;
            mem_addr_sel_c = 1'b1;
            mem_we_c       = (opc == OP_ST);
            if (bus.mem_ack) begin
               reg_en_c = (opc == OP_LD);
               ld_sel_c = (opc == OP_LD);
               state_n  = S_FETCH;
            end else if (wait_q == WAIT_LAST) begin
               state_n   = S_HALT;
               bus_err_n = 1'b1;
            end
         end
         S_HALT:  state_n = S_HALT;
         default: state_n = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         ir_q      <= '0;
         zf_q      <= 1'b0;
         sf_q      <= 1'b0;
         cf_q      <= 1'b0;
         wait_q    <= 8'd0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_n;
         bus_err_q <= bus_err_n;
         if (ir_load_c) ir_q <= bus.instr;
         if (flag_we_c) begin
            zf_q <= bus.zf;
            sf_q <= bus.sf;
            cf_q <= bus.cf;
         end
         // Any state change starts a fresh wait window for the next access.
         if (state_n != state_q)
            wait_q <= 8'd0;
         else if (mem_req_c && !bus.mem_ack)
            wait_q <= wait_q + 8'd1;
      end
   end

   // Outputs are forced low while reset is held so no strobe survives it.
   assign bus.op           = op_c & {2{~rst}};
   assign bus.imm_sel      = imm_sel_c & ~rst;
   assign bus.reg_en       = reg_en_c & ~rst;
   assign bus.ld_sel       = ld_sel_c & ~rst;
   assign bus.flag_we      = flag_we_c & ~rst;
   assign bus.ir_load      = ir_load_c & ~rst;
   assign bus.pc_inc       = pc_inc_c & ~rst;
   assign bus.pc_load      = pc_load_c & ~rst;
   assign bus.mem_req      = mem_req_c & ~rst;
   assign bus.mem_we       = mem_we_c & ~rst;
   assign bus.mem_addr_sel = mem_addr_sel_c & ~rst;
   assign bus.halted       = (state_q == S_HALT) & ~rst;
   assign bus.bus_err      = bus_err_q & ~rst;
   assign bus.state        = state_q & {3{~rst}};
endmodule

// File: tb/tb_cu_multicycle.sv
// Directed bench for cu_multicycle: instruction-level model builds the expected
// per-cycle output vector, one negedge process compares it against the DUT.
module tb_cu_multicycle;
   localparam int TO = 4;

   typedef struct packed {
      logic [1:0] op;
      logic       imm_sel;
      logic       reg_en;
      logic       ld_sel;
      logic       flag_we;
      logic       ir_load;
      logic       pc_inc;
      logic       pc_load;
      logic       mem_req;
      logic       mem_we;
      logic       mem_addr_sel;
      logic       halted;
      logic       bus_err;
      logic [2:0] state;
   } outs_t;

   typedef struct {
      outs_t o;
      string tag;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   outs_t act;
   exp_t  exp_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   logic       zf_m = 1'b0, sf_m = 1'b0, cf_m = 1'b0;
   int         pc_m = 0;

   cu_multicycle_if #(.INSTR_W(9)) bus ();

   cu_multicycle #(.INSTR_W(9), .MEM_TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign act = {bus.op, bus.imm_sel, bus.reg_en, bus.ld_sel, bus.flag_we,
                 bus.ir_load, bus.pc_inc, bus.pc_load, bus.mem_req, bus.mem_we,
                 bus.mem_addr_sel, bus.halted, bus.bus_err, bus.state};

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t it;
         it = exp_q.pop_front();
         n_tests++;
         if (act !== it.o) begin
            n_fail++;
            $display("FAIL %s: got %05h required %05h", it.tag, act, it.o);
         end
      end
   end

   task automatic step(input outs_t e, input string tag);
      exp_t it;
      it.o   = e;
      it.tag = tag;
      exp_q.push_back(it);
      @(posedge clk);
      #1;
   endtask

   task automatic check_lit(input string name, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, got, want);
      end
   endtask

   task automatic do_reset(input int n);
      outs_t e;
      e = '0;
      rst = 1'b1;
      bus.mem_ack = 1'b1;
      for (int i = 0; i < n; i++) step(e, "reset_zero");
      zf_m = 1'b0; sf_m = 1'b0; cf_m = 1'b0;
      pc_m = 0;
      rst = 1'b0;
   endtask

   task automatic halt_cycles(input int n, input logic berr);
      outs_t e;
      bus.mem_ack = 1'b1;
      for (int i = 0; i < n; i++) begin
         e = '0;
         e.state   = 3'd4;
         e.halted  = 1'b1;
         e.bus_err = berr;
         step(e, berr ? "halt_buserr" : "halt");
      end
   endtask

   // One instruction from FETCH to its last cycle; flags fz/fs/fc are presented
   // only during EXEC, their inverses elsewhere so stray sampling shows up.
   task automatic run_instr(input logic [3:0] opc, input logic [4:0] opd,
                            input int fwait, input int mwait,
                            input logic fz, input logic fs, input logic fc,
                            output int cycles);
      outs_t e;
      logic  jump, taken;
      cycles = 0;
      bus.instr = {opc, opd};
      bus.zf = ~fz; bus.sf = ~fs; bus.cf = ~fc;
      for (int w = 0; w <= fwait; w++) begin
         bus.mem_ack = (w == fwait);
         e = '0;
         e.state   = 3'd0;
         e.mem_req = 1'b1;
         if (w == fwait) begin
            e.ir_load = 1'b1;
            e.pc_inc  = 1'b1;
         end
         step(e, "fetch");
         cycles++;
      end
      pc_m++;
      bus.instr = ~{opc, opd};
      bus.mem_ack = 1'b1;
      jump  = (opc == 4'h1) || (opc == 4'h2) || (opc == 4'h3) || (opc == 4'hE);
      taken = (opc == 4'h1 && zf_m) || (opc == 4'h2 && cf_m) ||
              (opc == 4'h3 && !zf_m && !sf_m) || (opc == 4'hE);
      e = '0;
      e.state   = 3'd1;
      e.pc_load = taken;
      step(e, "decode");
      cycles++;
      if (taken) pc_m = int'(opd);
      if (opc == 4'h0 || jump || opc == 4'hF) return;
      if (opc == 4'hC || opc == 4'hD) begin
         for (int w = 0; w <= mwait; w++) begin
            bus.mem_ack = (w == mwait);
            e = '0;
            e.state        = 3'd3;
            e.mem_req      = 1'b1;
            e.mem_addr_sel = 1'b1;
            e.mem_we       = (opc == 4'hC);
            if (w == mwait && opc == 4'hD) begin
               e.reg_en = 1'b1;
               e.ld_sel = 1'b1;
            end
            step(e, (opc == 4'hC) ? "mem_st" : "mem_ld");
            cycles++;
         end
      end else begin
         bus.zf = fz; bus.sf = fs; bus.cf = fc;
         e = '0;
         e.state   = 3'd2;
         e.op      = opc[1:0];
         e.imm_sel = (opc[3:2] == 2'b01);
         e.flag_we = 1'b1;
         e.reg_en  = !(opc == 4'h4 || opc == 4'h8);
         step(e, "exec");
         cycles++;
         zf_m = fz; sf_m = fs; cf_m = fc;
      end
      bus.zf = 1'b1; bus.sf = 1'b1; bus.cf = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int    cyc;
      outs_t e;
      bus.instr = '0;
      bus.mem_ack = 1'b1;
      bus.zf = 1'b0; bus.sf = 1'b0; bus.cf = 1'b0;
      @(posedge clk);
      #1;
      do_reset(2);

      // Register add, zero wait: 3 cycles, op=01, write-back
      run_instr(4'b1001, 5'b00011, 0, 0, 1'b0, 1'b1, 1'b1, cyc);
      check_lit("add_cycles", cyc, 3);

      // CMP clear flags then JGT taken
      run_instr(4'b1000, 5'd0, 0, 0, 1'b0, 1'b0, 1'b0, cyc);
      run_instr(4'b0011, 5'd20, 0, 0, 1'b1, 1'b1, 1'b1, cyc);
      check_lit("jgt_taken_pc", pc_m, 20);
      check_lit("jump_cycles", cyc, 2);

      // CMP with zf=1 then JGT not taken, PC only increments
      run_instr(4'b1000, 5'd0, 0, 0, 1'b1, 1'b0, 1'b1, cyc);
      run_instr(4'b0011, 5'd7, 0, 0, 1'b0, 1'b0, 1'b0, cyc);
      check_lit("jgt_not_taken_pc", pc_m, 22);
      run_instr(4'b0010, 5'd9, 0, 0, 1'b0, 1'b0, 1'b0, cyc);
      run_instr(4'b0001, 5'd3, 0, 0, 1'b0, 1'b0, 1'b0, cyc);
      check_lit("jc_jz_taken_pc", pc_m, 3);

      // Immediate ops, one with fetch wait states
      run_instr(4'b0100, 5'd1, 0, 0, 1'b0, 1'b1, 1'b0, cyc);
      run_instr(4'b0101, 5'd2, 2, 0, 1'b0, 1'b0, 1'b1, cyc);
      check_lit("addi_wait_cycles", cyc, 5);

      // ST with the last acceptable fetch and mem waits (ack in cycle TO)
      run_instr(4'b1100, 5'd4, TO - 1, TO - 1, 1'b0, 1'b0, 1'b0, cyc);
      check_lit("st_wait_cycles", cyc, 9);
      run_instr(4'b1101, 5'd5, 0, 0, 1'b0, 1'b0, 1'b0, cyc);
      check_lit("ld_cycles", cyc, 3);
      run_instr(4'b0000, 5'd6, 0, 0, 1'b0, 1'b0, 1'b0, cyc);
      check_lit("nop_cycles", cyc, 2);
      run_instr(4'b1110, 5'd31, 0, 0, 1'b0, 1'b0, 1'b0, cyc);
      check_lit("jmp_pc", pc_m, 31);
      run_instr(4'b0001, 5'd8, 0, 0, 1'b0, 1'b0, 1'b0, cyc);
      check_lit("jz_not_taken_pc", pc_m, 32);

      // HLT: stays halted, acks ignored
      run_instr(4'b1111, 5'd0, 0, 0, 1'b0, 1'b0, 1'b0, cyc);
      check_lit("hlt_cycles", cyc, 2);
      halt_cycles(3, 1'b0);

      // Fetch timeout
      do_reset(1);
      bus.instr = 9'h1E3;
      bus.mem_ack = 1'b0;
      for (int i = 0; i < TO; i++) begin
         e = '0;
         e.mem_req = 1'b1;
         step(e, "fetch_wait");
      end
      halt_cycles(3, 1'b1);

      // Reset in the middle of a MEM access
      do_reset(1);
      bus.instr = {4'b1101, 5'd9};
      bus.mem_ack = 1'b1;
      e = '0; e.mem_req = 1'b1; e.ir_load = 1'b1; e.pc_inc = 1'b1;
      step(e, "fetch_pre_abort");
      e = '0; e.state = 3'd1;
      step(e, "decode_pre_abort");
      bus.mem_ack = 1'b0;
      e = '0; e.state = 3'd3; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
      step(e, "mem_pre_abort");
      do_reset(2);

      // Flags cleared by reset: JZ not taken
      run_instr(4'b0001, 5'd12, 0, 0, 1'b1, 1'b1, 1'b1, cyc);
      check_lit("jz_after_reset_pc", pc_m, 1);

      repeat (2) @(negedge clk);
      check_lit("expect_queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cu_multicycle.md
# cu_multicycle

Multi-cycle control unit for the parametrised CPU datapath, succeeding the single-cycle combinational decoder. It sequences each instruction through FETCH, DECODE, EXEC and MEM states over a req/ack memory handshake. It holds the instruction register and the flag register internally, adds LD, unconditional JMP, JZ, JC and HLT to the existing opcode map, and halts on a bus timeout. It sits between the program/data memory interface and the register file, ALU and PC.

## Interface
- `INSTR_W`, default 9: instruction width. Opcode is `instr[INSTR_W-1 -: 4]`. The operand field is consumed by the datapath, not this block.
- `MEM_TIMEOUT`, default 15: maximum number of cycles `mem_req` may wait for `mem_ack`. Legal range is 1..255.
- `clk` in, 1: the single clock. All state updates on the rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `instr` in, INSTR_W: memory read data. Captured into the IR on a FETCH ack.
- `mem_ack` in, 1: memory handshake acknowledge. Completes the access in the same cycle.
- `zf`, `sf`, `cf` in, 1 each: ALU flags. Sampled only when `flag_we`=1.
- `op` out, 2: ALU operation, equal to IR opcode[1:0] in EXEC, otherwise 0.
- `imm_sel` out, 1: ALU B operand is the immediate.
- `reg_en` out, 1: register file write enable.
- `ld_sel` out, 1: register write data comes from memory instead of the ALU.
- `flag_we` out, 1: flag register capture strobe.
- `ir_load` out, 1: IR capture strobe, exported for debug.
- `pc_inc` out, 1: PC increment.
- `pc_load` out, 1: PC loads the operand field.
- `mem_req` out, 1: memory request.
- `mem_we` out, 1: memory write (store).
- `mem_addr_sel` out, 1: 0 selects PC as the address, 1 selects the operand.
- `halted` out, 1: block is in HALT.
- `bus_err` out, 1: HALT was entered through a timeout.
- `state` out, 3: FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4.

## Operation
**Opcode map**
- 0000: NOP.
- 0001: JZ, taken if zf_q.
- 0010: JC, taken if cf_q.
- 0011: JGT, taken if !zf_q && !sf_q.
- 0100: CMPI. Flags only, no register write.
- 0101–0111: immediate ALU ops, with write-back.
- 1000: CMP. Flags only, no register write.
- 1001–1011: register ALU ops, with write-back.
- 1100: ST.
- 1101: LD.
- 1110: JMP, unconditional.
- 1111: HLT.

**FETCH**
- Drives `mem_req`=1, `mem_addr_sel`=0, `mem_we`=0.
- On `mem_ack`=1, in the same cycle: `ir_load`=1 and `pc_inc`=1. Next state is DECODE.

**DECODE** (one cycle)
- Jump opcodes:
  - Taken: `pc_load`=1.
  - Not taken: no PC action.
  - Next state is FETCH either way.
- NOP goes to FETCH.
- HLT goes to HALT.
- LD and ST go to MEM.
- ALU opcodes (01xx, 10xx) go to EXEC.

**EXEC** (one cycle)
- `op` = IR[1:0].
- `imm_sel`=1 for 01xx.
- `flag_we`=1. The flag register captures zf/sf/cf at the end of this cycle.
- `reg_en`=1 except for 0100 and 1000.
- Next state is FETCH.

**MEM**
- Drives `mem_req`=1, `mem_addr_sel`=1, and `mem_we`=1 for ST.
- On ack:
  - LD asserts `reg_en`=1 and `ld_sel`=1 in the ack cycle.
  - ST asserts nothing extra.
  - Next state is FETCH.

**HALT**
- `halted`=1. All other strobes are 0.
- Left only by reset.

**Timeout**
- A wait counter clears on entry to FETCH or MEM.
- It increments on each cycle with `mem_req`=1 and `mem_ack`=0.
- An ack in the Nth request cycle is accepted for N ≤ MEM_TIMEOUT.
- If the MEM_TIMEOUT-th request cycle has no ack, the next state is HALT with `bus_err`=1. No strobes fire.

**General rules**
- All outputs are zero in any state where they are not listed above.
- Flags are used only through the registered copies (zf_q, sf_q, cf_q), so a jump sees the flags of the most recent EXEC.
- An ack arriving when `mem_req`=0 is ignored.

## Timing
- **Reset:**
  - state=FETCH; IR=0; flags=0; counter=0; `halted`=0; `bus_err`=0.
  - While `rst` is asserted, all outputs are 0, `state` included.
  - The first cycle after release asserts `mem_req`.
- **Reset mid-operation:** an assertion in any state immediately drops `mem_req`, `reg_en` and all other strobes. No partial write completes.
- **Latencies with zero-wait ack:**
  - ALU instruction: 3 cycles.
  - Jump or NOP: 2 cycles.
  - LD/ST: 3 cycles.
  - HLT: 2 cycles to HALT.
  - Each memory wait cycle adds 1.
- **Mealy vs Moore:** `ir_load`, `pc_inc`, and LD's `reg_en`/`ld_sel` are combinational on `mem_ack`. All other outputs are Moore, decoded from state and IR.
- **Back-to-back:** CMP followed by JGT uses the flags captured in CMP's EXEC cycle. There is no forwarding hazard.

## Test plan
- **Reset and fetch:** release `rst` with `mem_ack`=1 → next cycle `mem_req`=1 and `ir_load`=`pc_inc`=1; the cycle after that `state`=1.
- **Register add write-back:** `instr`=1001_00011 (opcode 1001), zero-wait → EXEC cycle shows `op`=01, `imm_sel`=0, `reg_en`=1, `flag_we`=1; total 3 cycles.
- **CMP then JGT:** CMP with zf=0, sf=0 then JGT → `pc_load`=1 in DECODE. Repeat with zf=1 → `pc_load`=0, and the PC only increments.
- **ST with wait states:** ST with ack delayed 3 cycles → `mem_req`=`mem_we`=`mem_addr_sel`=1 held for 4 cycles; then FETCH with `mem_addr_sel`=0.
- **LD:** LD with zero-wait ack → `reg_en`=`ld_sel`=1 in the MEM ack cycle.
- **Timeout:** MEM_TIMEOUT=4 and `mem_ack` held 0 in FETCH → after 4 request cycles `state`=4, `halted`=1, `bus_err`=1; a later ack is ignored. Assert `rst` mid-MEM → all outputs go to 0 immediately and `state`=0.
